// File: rtl/exc_check_pipe.sv
// E-stage exception checker: detects Ov/AdEL/AdES, merges the result with the
// code inherited from earlier stages, and delivers it to CP0 through PIPE_DEPTH registered stages.
module exc_check_pipe #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       PIPE_DEPTH = 1,
    parameter logic [DATA_W-1:0] DM_BASE    = '0,
    parameter logic [DATA_W-1:0] DM_LIMIT   = DATA_W'(32'h0000_2FFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [4:0]        in_exccode,
    input  logic [2:0]        in_op,
    input  logic [1:0]        in_size,
    input  logic [DATA_W-1:0] in_s1,
    input  logic [DATA_W-1:0] in_s2,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic              stall,
    input  logic              flush,
    input  logic              exc_ack,
    output logic              out_valid,
    output logic [4:0]        out_exccode,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [DATA_W-1:0] out_badvaddr,
    output logic              exc_pending
);

    typedef struct packed {
        logic              vld;
        logic [4:0]        code;
        logic [31:0]       pc;
        logic              bd;
        logic [DATA_W-1:0] bva;
    } stage_t;

    stage_t stg_q [PIPE_DEPTH];
    stage_t stg_d [PIPE_DEPTH];
    logic   pend_q, pend_d;

    logic [DATA_W:0]   s1_x, s2_x, sum_x, dif_x, below_x, above_x;
    logic [DATA_W-1:0] addr;
    logic              sum_ov, dif_ov, misalign, addr_bad;
    logic [4:0]        code_c;
    logic [DATA_W-1:0] bva_c;
    logic              any_exc, capture, pend_set;
    stage_t            cap_c;

    assign s1_x   = {in_s1[DATA_W-1], in_s1};
    assign s2_x   = {in_s2[DATA_W-1], in_s2};
    assign sum_x  = s1_x + s2_x;
    assign dif_x  = s1_x - s2_x;
    assign sum_ov = sum_x[DATA_W] ^ sum_x[DATA_W-1];
    assign dif_ov = dif_x[DATA_W] ^ dif_x[DATA_W-1];
    assign addr   = sum_x[DATA_W-1:0];

    // Range bounds checked via borrow bits so a zero DM_BASE needs no special case.
    assign below_x  = {1'b0, addr} - {1'b0, DM_BASE};
    assign above_x  = {1'b0, DM_LIMIT} - {1'b0, addr};

    always_comb begin
        case (in_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = addr[0];
            default: misalign = (addr[1:0] != 2'b00);
        endcase
    end

    assign addr_bad = sum_ov | misalign | below_x[DATA_W] | above_x[DATA_W];

    always_comb begin
        code_c = '0;
        bva_c  = '0;
        if (in_exccode != 5'd0) begin
            code_c = in_exccode;
            if (in_exccode == 5'd4 || in_exccode == 5'd5) bva_c = DATA_W'(in_pc);
        end else begin
            case (in_op)
                3'd1: if (sum_ov) code_c = 5'd12;
                3'd2: if (dif_ov) code_c = 5'd12;
                3'd3: if (addr_bad) begin code_c = 5'd4; bva_c = addr; end
                3'd4: if (addr_bad) begin code_c = 5'd5; bva_c = addr; end
                default: ;
            endcase
        end
    end

    always_comb begin
        any_exc = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++)
            any_exc = any_exc | (stg_q[i].vld && stg_q[i].code != 5'd0);
    end

    assign capture = in_valid && !pend_q && !any_exc;

    always_comb begin
        cap_c = '0;
        if (capture) begin
            cap_c.vld  = 1'b1;
            cap_c.code = code_c;
            cap_c.pc   = in_pc;
            cap_c.bd   = in_bd;
            cap_c.bva  = bva_c;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) stg_d[i] = stg_q[i];
        if (flush) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) stg_d[i] = '0;
        end else if (!stall) begin
            stg_d[0] = cap_c;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) stg_d[i] = stg_q[i-1];
        end
    end

    // Set is applied after clear so a same-edge ack cannot drop a new exception.
    assign pend_set = stg_q[PIPE_DEPTH-1].vld && (stg_q[PIPE_DEPTH-1].code != 5'd0) && !stall;

    always_comb begin
        pend_d = pend_q;
        if (exc_ack)  pend_d = 1'b0;
        if (pend_set) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) stg_q[i] <= '0;
            pend_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) stg_q[i] <= stg_d[i];
            pend_q <= pend_d;
        end
    end

    assign out_valid    = stg_q[PIPE_DEPTH-1].vld;
    assign out_exccode  = stg_q[PIPE_DEPTH-1].code;
    assign out_pc       = stg_q[PIPE_DEPTH-1].pc;
    assign out_bd       = stg_q[PIPE_DEPTH-1].bd;
    assign out_badvaddr = stg_q[PIPE_DEPTH-1].bva;
    assign exc_pending  = pend_q;

endmodule

// File: tb/tb_exc_check_pipe.sv
// Directed bench for exc_check_pipe: vector table on a depth-1 instance plus
// hand sequences for squash/ack, stall, flush and async reset (depth-1 and depth-3).
module tb_exc_check_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_bd, stall, flush, exc_ack;
    logic [4:0]  in_exccode;
    logic [2:0]  in_op;
    logic [1:0]  in_size;
    logic [31:0] in_s1, in_s2, in_pc;

    logic        o1_valid, o1_bd, o1_pend, o3_valid, o3_bd, o3_pend;
    logic [4:0]  o1_code, o3_code;
    logic [31:0] o1_pc, o1_bva, o3_pc, o3_bva;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exc_check_pipe #(.DATA_W(32), .PIPE_DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_exccode(in_exccode),
        .in_op(in_op), .in_size(in_size), .in_s1(in_s1), .in_s2(in_s2),
        .in_pc(in_pc), .in_bd(in_bd), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .out_valid(o1_valid), .out_exccode(o1_code), .out_pc(o1_pc), .out_bd(o1_bd),
        .out_badvaddr(o1_bva), .exc_pending(o1_pend)
    );

    exc_check_pipe #(.DATA_W(32), .PIPE_DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_exccode(in_exccode),
        .in_op(in_op), .in_size(in_size), .in_s1(in_s1), .in_s2(in_s2),
        .in_pc(in_pc), .in_bd(in_bd), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .out_valid(o3_valid), .out_exccode(o3_code), .out_pc(o3_pc), .out_bd(o3_bd),
        .out_badvaddr(o3_bva), .exc_pending(o3_pend)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  exc;
        logic [4:0]  ecode;
        logic [31:0] ebva;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0; in_exccode = '0; in_op = '0; in_size = '0;
        in_s1 = '0; in_s2 = '0; in_pc = '0; in_bd = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [4:0] exc, input logic [31:0] pc,
                         input logic bd);
        in_valid = 1'b1; in_op = op; in_size = size; in_s1 = s1; in_s2 = s2;
        in_exccode = exc; in_pc = pc; in_bd = bd;
    endtask

    task automatic do_reset;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
        idle();
        tick(); tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'd1, 2'd0, 32'h7FFF_FFFF, 32'h1,         5'd0,  5'd12, 32'h0};
        vecs[1]  = '{3'd2, 2'd0, 32'h8000_0000, 32'h1,         5'd0,  5'd12, 32'h0};
        vecs[2]  = '{3'd1, 2'd0, 32'h5,         32'h7,         5'd0,  5'd0,  32'h0};
        vecs[3]  = '{3'd1, 2'd0, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0,  5'd0,  32'h0};
        vecs[4]  = '{3'd2, 2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0,  5'd12, 32'h0};
        vecs[5]  = '{3'd3, 2'd2, 32'h100,       32'h2,         5'd0,  5'd4,  32'h102};
        vecs[6]  = '{3'd3, 2'd1, 32'h100,       32'h2,         5'd0,  5'd0,  32'h0};
        vecs[7]  = '{3'd4, 2'd2, 32'h3000,      32'h0,         5'd0,  5'd5,  32'h3000};
        vecs[8]  = '{3'd4, 2'd2, 32'h2FFC,      32'h0,         5'd0,  5'd0,  32'h0};
        vecs[9]  = '{3'd1, 2'd0, 32'h7FFF_FFFF, 32'h1,         5'd10, 5'd10, 32'h0};
        vecs[10] = '{3'd0, 2'd0, 32'h0,         32'h0,         5'd4,  5'd4,  32'h0000_1028};
        vecs[11] = '{3'd3, 2'd0, 32'h2FFF,      32'h0,         5'd0,  5'd0,  32'h0};
        vecs[12] = '{3'd3, 2'd3, 32'h101,       32'h0,         5'd0,  5'd4,  32'h101};
        vecs[13] = '{3'd5, 2'd0, 32'h7FFF_FFFF, 32'h1,         5'd0,  5'd0,  32'h0};
        vecs[14] = '{3'd3, 2'd0, 32'h8000_0000, 32'h8000_0010, 5'd0,  5'd4,  32'h10};
        vecs[15] = '{3'd4, 2'd1, 32'h200,       32'hFFFF_FFFE, 5'd0,  5'd0,  32'h0};
        vecs[16] = '{3'd4, 2'd0, 32'h2FFF,      32'h1,         5'd0,  5'd5,  32'h3000};

        do_reset();
        chk("rst d1 valid", {31'b0, o1_valid}, 32'd0);
        chk("rst d1 code",  {27'b0, o1_code},  32'd0);
        chk("rst d1 pc",    o1_pc,             32'd0);
        chk("rst d1 bva",   o1_bva,            32'd0);
        chk("rst d1 pend",  {31'b0, o1_pend},  32'd0);
        chk("rst d3 valid", {31'b0, o3_valid}, 32'd0);
        chk("rst d3 pend",  {31'b0, o3_pend},  32'd0);

        // Vector table on the depth-1 instance: pc = 0x1000 + 4*i (vector 10 relies on this).
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].size, vecs[i].s1, vecs[i].s2, vecs[i].exc,
                  32'h1000 + 32'(i) * 4, i[0]);
            tick();
            chk($sformatf("v%0d valid", i), {31'b0, o1_valid}, 32'd1);
            chk($sformatf("v%0d code", i),  {27'b0, o1_code},  {27'b0, vecs[i].ecode});
            chk($sformatf("v%0d bva", i),   o1_bva,            vecs[i].ebva);
            chk($sformatf("v%0d pc", i),    o1_pc,             32'h1000 + 32'(i) * 4);
            chk($sformatf("v%0d bd", i),    {31'b0, o1_bd},    {31'b0, i[0]});
            idle();
            tick();
            chk($sformatf("v%0d pend", i), {31'b0, o1_pend}, {31'b0, vecs[i].ecode != 5'd0});
            exc_ack = 1'b1;
            tick();
            exc_ack = 1'b0;
            chk($sformatf("v%0d ackclr", i), {31'b0, o1_pend}, 32'd0);
        end

        // Squash until acknowledged.
        issue(3'd1, 2'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h100, 1'b0);
        tick();
        chk("sq exc code", {27'b0, o1_code}, 32'd12);
        issue(3'd1, 2'd0, 32'h1, 32'h1, 5'd0, 32'h104, 1'b0);
        tick();
        chk("sq y1 valid", {31'b0, o1_valid}, 32'd0);
        chk("sq pend set", {31'b0, o1_pend},  32'd1);
        in_pc = 32'h108;
        tick();
        chk("sq y2 valid", {31'b0, o1_valid}, 32'd0);
        in_pc = 32'h10C;
        tick();
        chk("sq y3 valid", {31'b0, o1_valid}, 32'd0);
        idle();
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("sq ack pend", {31'b0, o1_pend}, 32'd0);
        issue(3'd1, 2'd0, 32'h1, 32'h1, 5'd0, 32'h110, 1'b0);
        tick();
        chk("sq next valid", {31'b0, o1_valid}, 32'd1);
        chk("sq next pc",    o1_pc,             32'h110);
        chk("sq next code",  {27'b0, o1_code},  32'd0);

        // Set and ack on the same edge: set wins.
        issue(3'd1, 2'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h200, 1'b0);
        tick();
        idle();
        exc_ack = 1'b1;
        tick();
        chk("setack pend", {31'b0, o1_pend}, 32'd1);
        tick();
        exc_ack = 1'b0;
        chk("ack2 pend", {31'b0, o1_pend}, 32'd0);

        // Stall blocks the pending set and holds the output.
        issue(3'd2, 2'd0, 32'h8000_0000, 32'h1, 5'd0, 32'h300, 1'b1);
        tick();
        idle();
        stall = 1'b1;
        tick();
        chk("stl pend",  {31'b0, o1_pend},  32'd0);
        chk("stl valid", {31'b0, o1_valid}, 32'd1);
        chk("stl code",  {27'b0, o1_code},  32'd12);
        stall = 1'b0;
        tick();
        chk("stl rel pend",  {31'b0, o1_pend},  32'd1);
        chk("stl rel valid", {31'b0, o1_valid}, 32'd0);

        // Depth 3 with a two-cycle stall: latency becomes 5.
        do_reset();
        issue(3'd1, 2'd0, 32'h2, 32'h3, 5'd0, 32'h500, 1'b1);
        tick();
        idle();
        stall = 1'b1;
        tick(); tick();
        stall = 1'b0;
        tick();
        chk("lat4 valid", {31'b0, o3_valid}, 32'd0);
        tick();
        chk("lat5 valid", {31'b0, o3_valid}, 32'd1);
        chk("lat5 pc",    o3_pc,             32'h500);
        chk("lat5 bd",    {31'b0, o3_bd},    32'd1);
        chk("lat5 code",  {27'b0, o3_code},  32'd0);

        // Fill the depth-3 pipe, then flush together with stall.
        for (int k = 0; k < 3; k++) begin
            issue(3'd1, 2'd0, 32'h1, 32'h1, 5'd0, 32'h600 + 32'(k) * 4, 1'b0);
            tick();
        end
        chk("fill pc",    o3_pc,             32'h600);
        chk("fill valid", {31'b0, o3_valid}, 32'd1);
        idle();
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        chk("fl d3 valid", {31'b0, o3_valid}, 32'd0);
        chk("fl d3 pc",    o3_pc,             32'd0);
        chk("fl d1 valid", {31'b0, o1_valid}, 32'd0);
        tick();
        chk("fl +1 valid", {31'b0, o3_valid}, 32'd0);
        tick();
        chk("fl +2 valid", {31'b0, o3_valid}, 32'd0);

        // Flush leaves pending untouched.
        issue(3'd1, 2'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h700, 1'b0);
        tick();
        chk("fp d1 code", {27'b0, o1_code}, 32'd12);
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fp pend",  {31'b0, o1_pend},  32'd1);
        chk("fp valid", {31'b0, o1_valid}, 32'd0);
        tick();
        chk("fp pend hold", {31'b0, o1_pend}, 32'd1);

        // Exception in flight on depth 3, then asynchronous reset mid-cycle.
        issue(3'd1, 2'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h800, 1'b0);
        tick();
        idle();
        tick(); tick();
        chk("d3 exc valid", {31'b0, o3_valid}, 32'd1);
        chk("d3 exc code",  {27'b0, o3_code},  32'd12);
        chk("d3 exc pc",    o3_pc,             32'h800);
        chk("d3 exc bva",   o3_bva,            32'd0);
        #1 reset = 1'b0;
        #1;
        chk("arst d3 valid", {31'b0, o3_valid}, 32'd0);
        chk("arst d3 code",  {27'b0, o3_code},  32'd0);
        chk("arst d3 pc",    o3_pc,             32'd0);
        chk("arst d1 pend",  {31'b0, o1_pend},  32'd0);
        chk("arst d3 pend",  {31'b0, o3_pend},  32'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_check_pipe.md
Name: exc_check_pipe

Overview:
- Parametrised successor to the E-stage exception-code fixer for the MIPS pipeline.
- Checks each E-stage instruction for:
  - signed add/sub overflow (Ov),
  - load/store address errors (AdEL/AdES): address overflow, misalignment by access size, out-of-range data address.
- Merges the result with the exception code inherited from earlier stages.
- Carries the result through PIPE_DEPTH registered stages to CP0, with stall/flush. Holds a sticky pending flag that squashes younger instructions until CP0 acknowledges.

Parameters:
- DATA_W, 32, operand/address width (>=8).
- PIPE_DEPTH, 1, number of register stages between input and output (1..3).
- DM_BASE, 32'h0000_0000, lowest legal data address (inclusive).
- DM_LIMIT, 32'h0000_2FFF, highest legal data address (inclusive).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  E-stage slot holds a real instruction.
- in_exccode  in  5  code from earlier stages; 0 = none.
- in_op  in  3  0 none, 1 signed add, 2 signed sub, 3 load, 4 store; 5-7 treated as 0.
- in_size  in  2  access size: 0 byte, 1 half, 2 word; 3 treated as word.
- in_s1, in_s2  in  DATA_W  ALU operands (address = in_s1+in_s2 for load/store).
- in_pc  in  32  instruction PC.
- in_bd  in  1  instruction is in a branch delay slot.
- stall  in  1  hold all stages.
- flush  in  1  clear all stages to bubbles.
- exc_ack  in  1  one-cycle pulse: CP0 has taken the pending exception.
- out_valid  out  1  output stage holds a real instruction.
- out_exccode  out  5  final exception code.
- out_pc  out  32  PC of output-stage instruction.
- out_bd  out  1  delay-slot flag of output-stage instruction.
- out_badvaddr  out  DATA_W  faulting address for AdEL/AdES, else 0.
- exc_pending  out  1  sticky; exception delivered, not yet acknowledged.

Behaviour:
- Reset (async assert): all stages become bubbles (valid=0, code/pc/bd/badvaddr=0); exc_pending=0. Outputs stay 0 until a valid entry reaches the output.
- Detection is combinational at the input. Sums and differences are computed at DATA_W+1 bits, sign-extended; overflow is bit[DATA_W] != bit[DATA_W-1].
- Code priority:
  1. in_exccode != 0 passes through unchanged; in_badvaddr is 0 unless in_exccode==4 or 5, in which case it is in_pc.
  2. op 1/2 with overflow gives Ov (12).
  3. op 3 with address overflow, misalignment (half: addr[0]!=0; word: addr[1:0]!=0), or addr outside [DM_BASE, DM_LIMIT] gives AdEL (4); badvaddr = addr.
  4. op 4 under the same conditions gives AdES (5); badvaddr = addr.
  5. Otherwise 0.
- Latency: an accepted input appears at the outputs exactly PIPE_DEPTH cycles later, absent stall.
- stall=1: every stage holds its contents; inputs are ignored; exc_pending may still change by exc_ack.
- flush=1: every stage becomes a bubble on the next edge. flush beats stall. exc_pending is unaffected.
- Squash: the stage-0 capture becomes a bubble when in_valid=0, or exc_pending=1, or any stage currently holds valid with a nonzero code.
- exc_pending set: on the edge the output stage holds valid with a nonzero code and stall=0.
- exc_pending clear: on an edge with exc_ack=1.
- Simultaneous set and ack on the same edge: set wins, so pending stays 1.
- exc_ack while pending=0: no effect.
- Bubbles carry no exception and never set pending.

Test Plan:
- Add overflow: in_op=1, s1=32'h7FFF_FFFF, s2=1, valid, PIPE_DEPTH=1 -> next cycle out_exccode=12, out_valid=1; following edge exc_pending=1.
- Misaligned load: in_op=3, size=2, s1=32'h100, s2=2 -> out_exccode=4, out_badvaddr=32'h102. Same with size=1 -> code 0.
- Out-of-range store: in_op=4, size=2, s1=32'h3000, s2=0 -> code 5, badvaddr 32'h3000. Address 32'h2FFC -> code 0.
- Priority: in_exccode=10 (RI) with an overflowing add -> out_exccode=10, badvaddr=0.
- Squash/ack: after an exception, three further valid add instructions are issued -> all emerge out_valid=0. Pulse exc_ack -> exc_pending=0, and the next instruction emerges valid.
- Stall/flush/reset:
  - PIPE_DEPTH=3, stall held 2 cycles mid-flight -> latency becomes 5.
  - flush with stall both high -> all bubbles.
  - reset asserted mid-flight -> outputs and exc_pending immediately 0.
